// File: rtl/tank_gfx_pkg.sv
// Shared screen constants and pixel/sprite types for the tank graphics pipeline.
package tank_gfx_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb444_t;

    typedef struct packed {
        logic    hit;
        logic    blank;
        rgb444_t bg;
    } pix_stage_t;
endpackage

// File: rtl/sprite_addr_xform.sv
// Maps a sprite-local texel coordinate and facing direction to a row-major
// ROM address, rotating the square sprite in 90 degree steps.
module sprite_addr_xform
    import tank_gfx_pkg::*;
#(
    parameter int SPRITE_W = 32,
    localparam int CW = $clog2(SPRITE_W),
    localparam int AW = $clog2(SPRITE_W * SPRITE_W)
) (
    input  logic [CW-1:0] lx_i,
    input  logic [CW-1:0] ly_i,
    input  dir_t          dir_i,
    output logic [AW-1:0] addr_o
);
    localparam logic [CW-1:0] N    = CW'(SPRITE_W - 1);
    localparam logic [AW-1:0] W_AW = AW'(SPRITE_W);

    logic [CW-1:0] row;
    logic [CW-1:0] col;

    always_comb begin
        row = ly_i;
        col = lx_i;
        case (dir_i)
            DIR_UP:    begin row = ly_i;     col = lx_i;     end
            DIR_RIGHT: begin row = N - lx_i; col = ly_i;     end
            DIR_DOWN:  begin row = N - ly_i; col = N - lx_i; end
            DIR_LEFT:  begin row = lx_i;     col = N - ly_i; end
            default:   begin row = ly_i;     col = lx_i;     end
        endcase
    end

    assign addr_o = AW'(row) * W_AW + AW'(col);
endmodule

// File: rtl/tank_sprite_renderer.sv
// One scaled, rotated, colour-keyed sprite composited over the upstream pixel;
// position/direction/enable latch at the frame boundary so a frame never tears.
module tank_sprite_renderer
    import tank_gfx_pkg::*;
#(
    parameter int SPRITE_W        = 32,
    parameter int SPRITE_H        = 32,
    parameter int SCALE_SHIFT     = 0,
    parameter int IDX_W           = 4,
    parameter int ROM_LATENCY     = 1,
    parameter int TRANSPARENT_IDX = 0,
    parameter int V_ACTIVE        = 480
) (
    input  logic                                  vga_clk,
    input  logic                                  reset_n,
    input  logic [COORD_W-1:0]                    DrawX,
    input  logic [COORD_W-1:0]                    DrawY,
    input  logic                                  blank,
    input  logic                                  pos_valid,
    input  logic [COORD_W-1:0]                    pos_x,
    input  logic [COORD_W-1:0]                    pos_y,
    input  logic [1:0]                            dir,
    input  logic                                  sprite_en,
    input  logic [3:0]                            bg_red,
    input  logic [3:0]                            bg_green,
    input  logic [3:0]                            bg_blue,
    output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]  rom_address,
    input  logic [IDX_W-1:0]                      rom_q,
    output logic [IDX_W-1:0]                      pal_index,
    input  logic [3:0]                            pal_red,
    input  logic [3:0]                            pal_green,
    input  logic [3:0]                            pal_blue,
    output logic [3:0]                            red,
    output logic [3:0]                            green,
    output logic [3:0]                            blue,
    output logic                                  sprite_hit,
    output logic                                  frame_commit
);
    localparam int CW = $clog2(SPRITE_W);
    localparam int AW = $clog2(SPRITE_W * SPRITE_H);
    localparam logic [COORD_W:0] EXT = (COORD_W + 1)'(SPRITE_W << SCALE_SHIFT);

    if (SPRITE_H != SPRITE_W) begin : g_bad_shape
        $error("tank_sprite_renderer: SPRITE_H must equal SPRITE_W for rotation");
    end
    if (ROM_LATENCY < 1 || ROM_LATENCY > 3) begin : g_bad_latency
        $error("tank_sprite_renderer: ROM_LATENCY must be 1..3");
    end

    logic [COORD_W-1:0] pendX_q, pendY_q, actX_q, actY_q;
    dir_t               pendDir_q, actDir_q;
    logic               pendEn_q, actEn_q;
    logic               commit;

    assign commit       = (DrawX == '0) && (DrawY == COORD_W'(V_ACTIVE));
    assign frame_commit = commit && reset_n;

    // A strobe landing on the commit cycle bypasses pending so it shows next frame.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            pendX_q   <= '0;
            pendY_q   <= '0;
            pendDir_q <= DIR_UP;
            pendEn_q  <= 1'b0;
            actX_q    <= '0;
            actY_q    <= '0;
            actDir_q  <= DIR_UP;
            actEn_q   <= 1'b0;
        end else begin
            if (pos_valid) begin
                pendX_q   <= pos_x;
                pendY_q   <= pos_y;
                pendDir_q <= dir_t'(dir);
                pendEn_q  <= sprite_en;
            end
            if (commit) begin
                actX_q   <= pos_valid ? pos_x        : pendX_q;
                actY_q   <= pos_valid ? pos_y        : pendY_q;
                actDir_q <= pos_valid ? dir_t'(dir)  : pendDir_q;
                actEn_q  <= pos_valid ? sprite_en    : pendEn_q;
            end
        end
    end

    // Bounds are compared one bit wider so a sprite near the right/bottom edge clips.
    logic [COORD_W:0]   x11, y11, ax11, ay11;
    logic               hit0;
    logic [COORD_W-1:0] dx, dy;
    logic [CW-1:0]      lx, ly;
    logic [AW-1:0]      addr0;
    logic [AW-1:0]      romAddr_q;

    assign x11  = {1'b0, DrawX};
    assign y11  = {1'b0, DrawY};
    assign ax11 = {1'b0, actX_q};
    assign ay11 = {1'b0, actY_q};
    assign hit0 = actEn_q && (x11 >= ax11) && (x11 < ax11 + EXT)
                          && (y11 >= ay11) && (y11 < ay11 + EXT);
    assign dx   = DrawX - actX_q;
    assign dy   = DrawY - actY_q;
    assign lx   = CW'(dx >> SCALE_SHIFT);
    assign ly   = CW'(dy >> SCALE_SHIFT);

    sprite_addr_xform #(
        .SPRITE_W (SPRITE_W)
    ) u_xform (
        .lx_i   (lx),
        .ly_i   (ly),
        .dir_i  (actDir_q),
        .addr_o (addr0)
    );

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            romAddr_q <= '0;
        end else if (hit0) begin
            romAddr_q <= addr0;
        end
    end

    assign rom_address = romAddr_q;
    assign pal_index   = rom_q;

    pix_stage_t stage0;
    assign stage0 = '{hit: hit0, blank: blank,
                      bg: '{red: bg_red, green: bg_green, blue: bg_blue}};

    // Pixel attributes ride alongside the ROM access so they meet rom_q.
    for (genvar i = 0; i <= ROM_LATENCY; i++) begin : g_dly
        pix_stage_t stage_q;
        if (i == 0) begin : g_head
            always_ff @(posedge vga_clk) begin
                if (!reset_n) stage_q <= '0;
                else          stage_q <= stage0;
            end
        end else begin : g_tail
            always_ff @(posedge vga_clk) begin
                if (!reset_n) stage_q <= '0;
                else          stage_q <= g_dly[i-1].stage_q;
            end
        end
    end

    pix_stage_t tail;
    rgb444_t    pix_d, pix_q;
    logic       spriteHit_d, spriteHit_q;

    assign tail = g_dly[ROM_LATENCY].stage_q;

    always_comb begin
        pix_d       = '0;
        spriteHit_d = 1'b0;
        if (tail.blank) begin
            if (tail.hit && (rom_q != IDX_W'(TRANSPARENT_IDX))) begin
                pix_d       = '{red: pal_red, green: pal_green, blue: pal_blue};
                spriteHit_d = 1'b1;
            end else begin
                pix_d = tail.bg;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            pix_q       <= '0;
            spriteHit_q <= 1'b0;
        end else begin
            pix_q       <= pix_d;
            spriteHit_q <= spriteHit_d;
        end
    end

    assign red        = pix_q.red;
    assign green      = pix_q.green;
    assign blue       = pix_q.blue;
    assign sprite_hit = spriteHit_q;
endmodule

// File: tb/tb_tank_sprite_renderer.sv
// Drives two renderer instances (1x/latency 1 and 2x/latency 2) from one pixel
// stream and compares both against a coordinate-rotation reference model.
module tb_tank_sprite_renderer;
    localparam int LAT0 = 1;
    localparam int LAT1 = 2;
    localparam int SH0  = 0;
    localparam int SH1  = 1;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic [9:0] DrawX, DrawY, pos_x, pos_y;
    logic       blank, pos_valid, sprite_en;
    logic [1:0] dir;
    logic [3:0] bg_red, bg_green, bg_blue;

    logic [9:0] romAddr0, romAddr1;
    logic [3:0] romQ0, romQ1, palIdx0, palIdx1;
    logic [3:0] pr0, pg0, pb0, pr1, pg1, pb1;
    logic [3:0] r0, g0, b0, r1, g1, b1;
    logic       hitOut0, hitOut1, fc0, fc1;

    logic [3:0] romMem [1024];
    logic [3:0] pipe0;
    logic [3:0] pipe1 [2];

    typedef struct {
        int          due;
        logic [12:0] val;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   edgeCount = 0;
    int   total = 0;
    int   bad = 0;
    int   pendX = 0, pendY = 0, pendDir = 0, actX = 0, actY = 0, actDir = 0;
    bit   pendEn = 0, actEn = 0;
    int   expAddr0 = 0, expAddr1 = 0;

    always #5 vga_clk = ~vga_clk;

    function automatic logic [11:0] palColor(input logic [3:0] idx);
        return {idx, idx ^ 4'hA, ~idx};
    endfunction

    // External ROMs with 1 and 2 cycles of read latency, plus combinational palettes.
    always @(posedge vga_clk) begin
        pipe0    <= romMem[romAddr0];
        pipe1[0] <= romMem[romAddr1];
        pipe1[1] <= pipe1[0];
    end
    assign romQ0 = pipe0;
    assign romQ1 = pipe1[1];
    assign {pr0, pg0, pb0} = palColor(palIdx0);
    assign {pr1, pg1, pb1} = palColor(palIdx1);

    tank_sprite_renderer #(.SCALE_SHIFT(SH0), .ROM_LATENCY(LAT0)) dut0 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_valid(pos_valid), .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .sprite_en(sprite_en),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue), .rom_address(romAddr0),
        .rom_q(romQ0), .pal_index(palIdx0), .pal_red(pr0), .pal_green(pg0), .pal_blue(pb0),
        .red(r0), .green(g0), .blue(b0), .sprite_hit(hitOut0), .frame_commit(fc0));

    tank_sprite_renderer #(.SCALE_SHIFT(SH1), .ROM_LATENCY(LAT1)) dut1 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_valid(pos_valid), .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .sprite_en(sprite_en),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue), .rom_address(romAddr1),
        .rom_q(romQ1), .pal_index(palIdx1), .pal_red(pr1), .pal_green(pg1), .pal_blue(pb1),
        .red(r1), .green(g1), .blue(b1), .sprite_hit(hitOut1), .frame_commit(fc1));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: rotate the up-facing (row,col) pair clockwise once per direction step.
    function automatic logic [12:0] modelPixel(input int sh, input int x, input int y,
                                               input bit bl, input logic [11:0] bg,
                                               output bit inBox, output int addr);
        int ext, r, c, t;
        logic [3:0] idx;
        ext   = 32 << sh;
        inBox = 0;
        addr  = 0;
        if (actEn && x >= actX && x < actX + ext && y >= actY && y < actY + ext) begin
            inBox = 1;
            c = (x - actX) >> sh;
            r = (y - actY) >> sh;
            for (int k = 0; k < actDir; k++) begin
                t = r;
                r = 31 - c;
                c = t;
            end
            addr = r * 32 + c;
        end
        if (!bl) return 13'h0;
        idx = romMem[addr];
        if (inBox && idx != 4'd0) return {1'b1, palColor(idx)};
        return {1'b0, bg};
    endfunction

    task automatic applyStimulus(input int x, input int y, input bit bl,
                                 input logic [11:0] bg, input bit rst);
        int          e, a0, a1;
        bit          in0, in1;
        logic [12:0] v0, v1;
        exp_t        h;
        e = edgeCount + 1;
        DrawX   = 10'(x);
        DrawY   = 10'(y);
        blank   = bl;
        {bg_red, bg_green, bg_blue} = bg;
        reset_n = !rst;
        #2;
        checkOutput("commit0", 32'(fc0), 32'(!rst && x == 0 && y == 480));
        checkOutput("commit1", 32'(fc1), 32'(!rst && x == 0 && y == 480));
        if (rst) begin
            while (q0.size() > 0 && q0[$].due >= e) void'(q0.pop_back());
            while (q1.size() > 0 && q1[$].due >= e) void'(q1.pop_back());
            for (int k = 0; k <= LAT0 + 1; k++) q0.push_back('{due: e + k, val: 13'h0});
            for (int k = 0; k <= LAT1 + 1; k++) q1.push_back('{due: e + k, val: 13'h0});
            pendX = 0; pendY = 0; pendDir = 0; pendEn = 0;
            actX = 0; actY = 0; actDir = 0; actEn = 0;
            expAddr0 = 0;
            expAddr1 = 0;
        end else begin
            v0 = modelPixel(SH0, x, y, bl, bg, in0, a0);
            v1 = modelPixel(SH1, x, y, bl, bg, in1, a1);
            q0.push_back('{due: e + LAT0 + 1, val: v0});
            q1.push_back('{due: e + LAT1 + 1, val: v1});
            if (in0) expAddr0 = a0;
            if (in1) expAddr1 = a1;
            if (x == 0 && y == 480) begin
                if (pos_valid) begin
                    actX = int'(pos_x); actY = int'(pos_y); actDir = int'(dir); actEn = sprite_en;
                end else begin
                    actX = pendX; actY = pendY; actDir = pendDir; actEn = pendEn;
                end
            end
            if (pos_valid) begin
                pendX = int'(pos_x); pendY = int'(pos_y); pendDir = int'(dir); pendEn = sprite_en;
            end
        end
        @(posedge vga_clk);
        edgeCount++;
        #1;
        pos_valid = 1'b0;
        checkOutput("addr0", 32'(romAddr0), 32'(expAddr0));
        checkOutput("addr1", 32'(romAddr1), 32'(expAddr1));
        if (q0.size() > 0 && q0[0].due == edgeCount) begin
            h = q0.pop_front();
            checkOutput("pix0", 32'({hitOut0, r0, g0, b0}), 32'(h.val));
        end
        if (q1.size() > 0 && q1[0].due == edgeCount) begin
            h = q1.pop_front();
            checkOutput("pix1", 32'({hitOut1, r1, g1, b1}), 32'(h.val));
        end
    endtask

    task automatic randomPixels(input int n, input int xlo, input int xhi,
                                input int ylo, input int yhi);
        for (int i = 0; i < n; i++) begin
            applyStimulus(int'($urandom_range(xhi, xlo)), int'($urandom_range(yhi, ylo)),
                          ($urandom_range(7, 0) != 0), 12'($urandom), 1'b0);
        end
    endtask

    task automatic loadPos(input int px, input int py, input int pd, input bit pe);
        pos_valid = 1'b1;
        pos_x     = 10'(px);
        pos_y     = 10'(py);
        dir       = 2'(pd);
        sprite_en = pe;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(700 - 50, 500, 1'b0, 12'h000, 1'b0);
    endtask

    int dirAddr [3];

    initial begin
        dirAddr = '{992, 1023, 31};
        reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0; pos_valid = 1'b0;
        pos_x = '0; pos_y = '0; dir = '0; sprite_en = 1'b0;
        {bg_red, bg_green, bg_blue} = 12'h000;
        for (int i = 0; i < 1024; i++) romMem[i] = 4'(i);

        applyStimulus(5, 5, 1'b1, 12'hF00, 1'b1);
        applyStimulus(5, 5, 1'b1, 12'hF00, 1'b1);
        checkOutput("rstRgb", 32'({r0, g0, b0}), 32'h0);
        checkOutput("rstHit", 32'(hitOut0), 32'h0);
        for (int i = 0; i < 4; i++) applyStimulus(5, 5, 1'b1, 12'hF00, 1'b0);
        checkOutput("bgOut", 32'({r0, g0, b0}), 32'hF00);

        $display("[TB] place sprite at (100,50) facing up; last of two strobes wins");
        loadPos(300, 300, 2, 1'b1);
        applyStimulus(10, 10, 1'b1, 12'h0F0, 1'b0);
        loadPos(100, 50, 0, 1'b1);
        applyStimulus(11, 10, 1'b1, 12'h0F0, 1'b0);
        applyStimulus(639, 479, 1'b1, 12'h0F0, 1'b0);
        applyStimulus(0, 480, 1'b0, 12'h000, 1'b0);
        applyStimulus(100, 50, 1'b1, 12'h00F, 1'b0);
        checkOutput("addrTL", 32'(romAddr0), 32'd0);
        applyStimulus(131, 81, 1'b1, 12'h00F, 1'b0);
        checkOutput("addrBR", 32'(romAddr0), 32'd1023);
        applyStimulus(132, 50, 1'b1, 12'h00F, 1'b0);
        randomPixels(300, 80, 150, 30, 100);

        for (int d = 1; d < 4; d++) begin
            loadPos(100, 50, d, 1'b1);
            applyStimulus(300, 200, 1'b1, 12'h123, 1'b0);
            applyStimulus(0, 480, 1'b0, 12'h000, 1'b0);
            applyStimulus(100, 50, 1'b1, 12'h456, 1'b0);
            checkOutput("addrDir", 32'(romAddr0), 32'(dirAddr[d-1]));
            randomPixels(100, 90, 140, 40, 90);
        end

        $display("[TB] random ROM, sprite at origin");
        idle(5);
        for (int i = 0; i < 1024; i++) romMem[i] = 4'($urandom_range(15, 0));
        loadPos(0, 0, 0, 1'b1);
        applyStimulus(300, 300, 1'b1, 12'h789, 1'b0);
        applyStimulus(0, 480, 1'b0, 12'h000, 1'b0);
        applyStimulus(1, 1, 1'b1, 12'h789, 1'b0);
        checkOutput("addrScl0", 32'(romAddr1), 32'd0);
        applyStimulus(63, 63, 1'b1, 12'h789, 1'b0);
        checkOutput("addrScl1", 32'(romAddr1), 32'd1023);
        applyStimulus(64, 0, 1'b1, 12'h789, 1'b0);
        randomPixels(200, 0, 80, 0, 80);

        $display("[TB] right-edge clipping at x=630");
        loadPos(630, 100, int'($urandom_range(3, 0)), 1'b1);
        applyStimulus(0, 480, 1'b0, 12'h000, 1'b0);
        randomPixels(100, 0, 21, 95, 140);
        randomPixels(100, 620, 639, 95, 140);
        loadPos(630, 100, 0, 1'b1);
        applyStimulus(0, 480, 1'b0, 12'h000, 1'b0);
        applyStimulus(635, 100, 1'b1, 12'hABC, 1'b0);
        checkOutput("addrClip", 32'(romAddr0), 32'd5);

        $display("[TB] strobe coincident with commit");
        applyStimulus(5, 5, 1'b1, 12'h111, 1'b0);
        loadPos(200, 200, 0, 1'b1);
        applyStimulus(0, 480, 1'b0, 12'h000, 1'b0);
        applyStimulus(201, 200, 1'b1, 12'h222, 1'b0);
        checkOutput("addrByp", 32'(romAddr0), 32'd1);
        randomPixels(150, 180, 280, 180, 280);

        $display("[TB] reset mid-line");
        for (int x = 200; x < 206; x++) applyStimulus(x, 210, 1'b1, 12'h333, 1'b0);
        applyStimulus(206, 210, 1'b1, 12'h333, 1'b1);
        checkOutput("rstMid", 32'({hitOut0, r0, g0, b0}), 32'h0);
        randomPixels(100, 190, 270, 190, 270);
        loadPos(200, 200, 3, 1'b1);
        applyStimulus(0, 480, 1'b0, 12'h000, 1'b0);
        randomPixels(150, 190, 270, 190, 270);
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
